instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 24 ++
 rtl/instr_mem_loader.sv | 110 +++++++++++
 tb/tb_instr_mem_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// the terminator word and a little-endian byte-lane insert helper.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [31:0] TERMINATOR = 32'h0000_0000;

  // Drops byte b into lane idx of acc (lane 0 = bits 7:0).
  function automatic logic [31:0] place_byte(input logic [31:0] acc,
                                             input logic [7:0]  b,
                                             input logic [1:0]  idx);
    logic [31:0] r;
    r = acc;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Collects a byte stream into little-endian 32-bit words and writes them to
// instruction memory; an all-zero word or MAX_WORDS writes ends the session.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [7:0]  wa,
  output logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic        full,
  output logic [6:0]  word_count
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_WORDS);

  state_e      state_q;
  logic [7:0]  addr_q;
  logic [6:0]  count_q;
  logic [1:0]  idx_q;
  logic [31:0] asm_q;
  logic        full_q;
  logic        we_q;
  logic [7:0]  wa_q;
  logic [31:0] wd_q;

  logic [31:0] asm_d;
  logic [6:0]  count_d;

  assign asm_d   = place_byte(asm_q, byte_in, idx_q);
  assign count_d = count_q + 7'd1;

  // The write strobe and its address/data are loaded on the edge that accepts
  // the 4th byte, so they are already valid during the single WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 8'd0;
      count_q <= 7'd0;
      idx_q   <= 2'd0;
      asm_q   <= 32'd0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= 8'd0;
      wd_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_COLLECT;
            addr_q  <= 8'd0;
            count_q <= 7'd0;
            idx_q   <= 2'd0;
            asm_q   <= 32'd0;
            full_q  <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (byte_valid) begin
            asm_q <= asm_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= ST_WRITE;
              if (asm_d != TERMINATOR) begin
                we_q <= 1'b1;
                wa_q <= addr_q;
                wd_q <= asm_d;
              end
            end
          end
        end
        ST_WRITE: begin
          we_q <= 1'b0;
          if (asm_q == TERMINATOR) begin
            state_q <= ST_DONE;
            full_q  <= 1'b0;
          end else begin
            addr_q  <= addr_q + 8'd4;
            count_q <= count_d;
            if (count_d == MAX_CNT) begin
              state_q <= ST_DONE;
              full_q  <= 1'b1;
            end else begin
              state_q <= ST_COLLECT;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = (state_q == ST_COLLECT);
  assign busy       = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign full       = full_q;
  assign we         = we_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: two instances (MAX_WORDS 64 and 4) share one
// stimulus stream and are each checked every cycle against a byte/word model.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;

  logic [1:0]       br, we_o, busy_o, done_o, full_o;
  logic [1:0][7:0]  wa_o;
  logic [1:0][31:0] wd_o;
  logic [1:0][6:0]  wc_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.MAX_WORDS(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(br[0]), .we(we_o[0]), .wa(wa_o[0]),
    .wd(wd_o[0]), .busy(busy_o[0]), .done(done_o[0]), .full(full_o[0]),
    .word_count(wc_o[0])
  );

  instr_mem_loader #(.MAX_WORDS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(br[1]), .we(we_o[1]), .wa(wa_o[1]),
    .wd(wd_o[1]), .busy(busy_o[1]), .done(done_o[1]), .full(full_o[1]),
    .word_count(wc_o[1])
  );

  // Behavioural model: a session either gathers bytes, spends one cycle
  // writing the gathered word, or sits waiting for start.
  int          maxw [2] = '{64, 4};
  bit          m_collect [2];
  bit          m_writing [2];
  bit          m_done [2];
  bit          m_full [2];
  int          m_count [2];
  int          m_nb [2];
  logic [7:0]  m_addr [2];
  logic [7:0]  m_wa [2];
  logic [31:0] m_wd [2];
  logic [31:0] m_acc [2];
  logic [31:0] m_word [2];

  logic [39:0] log0 [$];
  logic [39:0] log1 [$];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t", name, d, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_collect[d] = 0; m_writing[d] = 0; m_done[d] = 0; m_full[d] = 0;
      m_count[d] = 0; m_nb[d] = 0; m_addr[d] = 8'd0; m_wa[d] = 8'd0;
      m_wd[d] = 32'd0; m_acc[d] = 32'd0; m_word[d] = 32'd0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (m_writing[d]) begin
        m_writing[d] = 0;
        if (m_word[d] == 32'd0) begin
          m_done[d] = 1; m_full[d] = 0;
        end else begin
          m_count[d] = m_count[d] + 1;
          m_addr[d] = m_addr[d] + 8'd4;
          if (m_count[d] == maxw[d]) begin
            m_done[d] = 1; m_full[d] = 1;
          end else begin
            m_collect[d] = 1;
          end
        end
      end else if (m_collect[d]) begin
        if (byte_valid) begin
          m_acc[d] = m_acc[d] + (32'(byte_in) << (8 * m_nb[d]));
          m_nb[d] = m_nb[d] + 1;
          if (m_nb[d] == 4) begin
            m_word[d] = m_acc[d];
            m_acc[d] = 32'd0; m_nb[d] = 0;
            m_collect[d] = 0; m_writing[d] = 1;
            if (m_word[d] != 32'd0) begin
              m_wa[d] = m_addr[d]; m_wd[d] = m_word[d];
            end
          end
        end
      end else if (start) begin
        m_collect[d] = 1; m_done[d] = 0; m_full[d] = 0; m_count[d] = 0;
        m_addr[d] = 8'd0; m_acc[d] = 32'd0; m_nb[d] = 0;
      end
    end
  endtask

  // Compare on the falling edge; advance the model on the rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int d = 0; d < 2; d++) begin
        chk("byte_ready", d, 32'(br[d]), 32'(m_collect[d]));
        chk("busy", d, 32'(busy_o[d]), 32'(m_collect[d] | m_writing[d]));
        chk("done", d, 32'(done_o[d]), 32'(m_done[d]));
        chk("full", d, 32'(full_o[d]), 32'(m_full[d]));
        chk("word_count", d, 32'(wc_o[d]), 32'(m_count[d]));
        chk("we", d, 32'(we_o[d]), 32'(m_writing[d] && (m_word[d] != 32'd0)));
        chk("wa", d, 32'(wa_o[d]), 32'(m_wa[d]));
        chk("wd", d, wd_o[d], m_wd[d]);
      end
      if (we_o[0]) log0.push_back({wa_o[0], wd_o[0]});
      if (we_o[1]) log1.push_back({wa_o[1], wd_o[1]});
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit st);
    for (int i = 0; i < 4; i++) begin
      byte_in = w[8*i +: 8];
      byte_valid = 1'b1;
      start = st;
      tick();
    end
    byte_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n0, n1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_we", d, 32'(we_o[d]), 32'd0);
      chk("rst_wa", d, 32'(wa_o[d]), 32'd0);
      chk("rst_wc", d, 32'(wc_o[d]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("idle_ready", 1, 32'(br[1]), 32'd0);

    // Two instructions followed by the terminator.
    pulse_start();
    send_word(32'h0010_0193, 1'b0);
    send_word(32'h0FF0_0083, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    chk("prog_nwrites", 0, 32'(log0.size()), 32'd2);
    if (log0.size() >= 2) begin
      chk("prog_w0", 0, log0[0], 40'h00_0010_0193);
      chk("prog_w1", 0, log0[1], 40'h04_0FF0_0083);
    end
    for (int d = 0; d < 2; d++) begin
      chk("prog_done", d, 32'(done_o[d]), 32'd1);
      chk("prog_full", d, 32'(full_o[d]), 32'd0);
      chk("prog_wc", d, 32'(wc_o[d]), 32'd2);
    end
    chk("model_count", 0, 32'(m_count[0]), 32'd2);

    // Restart from DONE, then a word delivered with gaps in byte_valid.
    n0 = log0.size(); n1 = log1.size();
    pulse_start();
    chk("restart_wc", 0, 32'(wc_o[0]), 32'd0);
    chk("restart_done", 1, 32'(done_o[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hDEAD_BEEF;
      byte_in = w[8*i +: 8];
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      byte_in = 8'hAA;
      tick();
    end
    chk("gap_nwrites", 0, 32'(log0.size() - n0), 32'd1);
    if (log0.size() > n0) chk("gap_word", 0, log0[n0], 40'h00_DEAD_BEEF);

    // Start held during busy words must be ignored; MAX_WORDS=4 instance fills.
    send_word(32'h0102_0304, 1'b1);
    send_word(32'h0506_0708, 1'b1);
    send_word(32'h090A_0B0C, 1'b0);
    send_word(32'h0D0E_0F10, 1'b0);
    chk("busy_wc", 0, 32'(wc_o[0]), 32'd5);
    chk("busy_state", 0, 32'(busy_o[0]), 32'd1);
    chk("fill_nwrites", 1, 32'(log1.size() - n1), 32'd4);
    if (log1.size() >= n1 + 4) begin
      chk("fill_w0", 1, 32'(log1[n1][39:32]), 32'h00);
      chk("fill_w1", 1, 32'(log1[n1+1][39:32]), 32'h04);
      chk("fill_w2", 1, 32'(log1[n1+2][39:32]), 32'h08);
      chk("fill_w3", 1, 32'(log1[n1+3][39:32]), 32'h0C);
    end
    chk("fill_done", 1, 32'(done_o[1]), 32'd1);
    chk("fill_full", 1, 32'(full_o[1]), 32'd1);
    chk("fill_ready", 1, 32'(br[1]), 32'd0);
    chk("fill_wc", 1, 32'(wc_o[1]), 32'd4);

    // Reset after two accepted bytes aborts the partial word.
    pulse_start();
    n0 = log0.size(); n1 = log1.size();
    byte_valid = 1'b1;
    byte_in = 8'h55; tick();
    byte_in = 8'h66; tick();
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("abort_busy", d, 32'(busy_o[d]), 32'd0);
      chk("abort_wa", d, 32'(wa_o[d]), 32'd0);
      chk("abort_wd", d, wd_o[d], 32'd0);
      chk("abort_wc", d, 32'(wc_o[d]), 32'd0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_nowrite", 0, 32'(log0.size() - n0), 32'd0);
    chk("abort_idle", 1, 32'(busy_o[1]), 32'd0);
    n0 = log0.size();
    pulse_start();
    send_word(32'h1122_3344, 1'b0);
    chk("after_abort_n", 0, 32'(log0.size() - n0), 32'd1);
    if (log0.size() > n0) chk("after_abort_w", 0, log0[n0], 40'h00_1122_3344);

    // Randomized traffic checked by the model on every cycle.
    for (int c = 0; c < 4000; c++) begin
      bit zero_mode;
      zero_mode = ((c / 150) % 3) == 0;
      start = ($urandom_range(0, 11) == 0);
      byte_valid = ($urandom_range(0, 3) != 0);
      if (zero_mode && ($urandom_range(0, 3) != 0)) byte_in = 8'h00;
      else byte_in = 8'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    byte_valid = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
